// File: rtl/adder_arb_pkg.sv
// Shared constants for the adder arbiter: operand width fixed by the adder,
// FSM state encoding and the requester-id width helper.
// Macro: ADDER_ARB_STATS_EN (per-requester grant counters) is used by adder_arbiter.
package adder_arb_pkg;

  localparam int unsigned ADD_W = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Width of a requester index; never below 1 bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder.sv
// 6-bit combinational Kogge-Stone prefix adder.
// Ports: x0..x5, y0..y5 operands (bit0 = LSB), s0..s5 sum bits, ov carry out.
module adder (
  input  logic x0, input logic x1, input logic x2,
  input  logic x3, input logic x4, input logic x5,
  input  logic y0, input logic y1, input logic y2,
  input  logic y3, input logic y4, input logic y5,
  output logic s0, output logic s1, output logic s2,
  output logic s3, output logic s4, output logic s5,
  output logic ov
);

  logic [5:0] a, b, p, g0, g1, p1, g2, p2, g3, c, s;

  assign a  = {x5, x4, x3, x2, x1, x0};
  assign b  = {y5, y4, y3, y2, y1, y0};
  assign p  = a ^ b;
  assign g0 = a & b;

  // Prefix levels at distances 1, 2 and 4; g3[i] is the group generate of bits i..0.
  assign g1 = g0 | (p & {g0[4:0], 1'b0});
  assign p1 = p & {p[4:0], 1'b1};
  assign g2 = g1 | (p1 & {g1[3:0], 2'b00});
  assign p2 = p1 & {p1[3:0], 2'b11};
  assign g3 = g2 | (p2 & {g2[1:0], 4'b0000});

  assign c = {g3[4:0], 1'b0};
  assign s = p ^ c;

  assign {s5, s4, s3, s2, s1, s0} = s;
  assign ov = g3[5];

endmodule

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Ports: req_i requests, ptr_i search start, oh_c_o one-hot winner, idx_c_o winner index,
//        any_c_o at least one request present.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  oh_c_o,
  output logic [IW-1:0] idx_c_o,
  output logic          any_c_o
);

  int unsigned j;

  always_comb begin
    oh_c_o  = '0;
    idx_c_o = '0;
    any_c_o = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr_i) + i) % N;
      if (!any_c_o && req_i[j]) begin
        any_c_o   = 1'b1;
        idx_c_o   = IW'(j);
        oh_c_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 6-bit adder among N_REQ requesters.
// Operands are captured at grant, the sum is registered one cycle later and
// returned on a valid/ready response channel tagged with the requester id.
// Ports: clk, rst (sync, active-high), req/x_in/y_in request side, gnt one-hot grant pulse,
//        rsp_valid/rsp_id/rsp_sum/rsp_ready response side,
//        stat_cnt per-requester saturating grant counters (only with ADDER_ARB_STATS_EN).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = ADD_W
`ifdef ADDER_ARB_STATS_EN
  ,parameter int unsigned CNT_W = 8
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*W-1:0]         x_in,
  input  logic [N_REQ*W-1:0]         y_in,
  output logic [N_REQ-1:0]           gnt,
  output logic                       rsp_valid,
  output logic [id_w(N_REQ)-1:0]     rsp_id,
  output logic [W:0]                 rsp_sum,
  input  logic                       rsp_ready
`ifdef ADDER_ARB_STATS_EN
  ,output logic [N_REQ*CNT_W-1:0]    stat_cnt
`endif
);

  localparam int unsigned IW = id_w(N_REQ);

  if (W != ADD_W) begin : g_bad_w
    $error("adder_arbiter: W must be 6");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("adder_arbiter: N_REQ must be 2..8");
  end

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [W-1:0]     op_x_q, op_x_d, op_y_q, op_y_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;
  logic [W:0]       rsp_sum_q, rsp_sum_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [W-1:0]     x_arr [N_REQ];
  logic [W-1:0]     y_arr [N_REQ];
  logic [W:0]       sum_c;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign x_arr[k] = x_in[k*W +: W];
    assign y_arr[k] = y_in[k*W +: W];
  end

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .oh_c_o  (pick_oh),
    .idx_c_o (pick_idx),
    .any_c_o (pick_any)
  );

  // Single shared adder, driven only from the captured operands.
  adder u_adder (
    .x0(op_x_q[0]), .x1(op_x_q[1]), .x2(op_x_q[2]),
    .x3(op_x_q[3]), .x4(op_x_q[4]), .x5(op_x_q[5]),
    .y0(op_y_q[0]), .y1(op_y_q[1]), .y2(op_y_q[2]),
    .y3(op_y_q[3]), .y4(op_y_q[4]), .y5(op_y_q[5]),
    .s0(sum_c[0]), .s1(sum_c[1]), .s2(sum_c[2]),
    .s3(sum_c[3]), .s4(sum_c[4]), .s5(sum_c[5]),
    .ov(sum_c[6])
  );

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    gnt_d       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          op_x_d  = x_arr[pick_idx];
          op_y_d  = y_arr[pick_idx];
          owner_d = pick_idx;
          gnt_d   = pick_oh;
          ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        rsp_sum_d   = sum_c;
        rsp_id_d    = owner_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

`ifdef ADDER_ARB_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of grant pulses per requester.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_q[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (N_REQ=4, W=6).
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [23:0] x_in, y_in;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [6:0]  rsp_sum;
  logic        rsp_ready;
`ifdef ADDER_ARB_STATS_EN
  logic [31:0] stat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .x_in      (x_in),
    .y_in      (y_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready)
`ifdef ADDER_ARB_STATS_EN
    ,.stat_cnt (stat_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; rsp_ready = 1'b1;
    x_in = 24'hFFFFFF; y_in = 24'hFFFFFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || rsp_sum !== 7'd0 || rsp_id !== 2'd0) begin
        errors++;
        $display("FAIL reset cyc%0d: gnt=%b valid=%b sum=%0d id=%0d, want 0000/0/0/0",
                 c, gnt, rsp_valid, rsp_sum, rsp_id);
      end
    end
    rst = 1'b0; req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_noreq: gnt=%b valid=%b, want 0000/0", gnt, rsp_valid);
    end
  endtask

  task automatic test_single();
    req = 4'b0100; x_in[12 +: 6] = 6'd5; y_in[12 +: 6] = 6'd9; rsp_ready = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0100 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt: gnt=%b valid=%b, want 0100/0", gnt, rsp_valid);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 7'd14) begin
      errors++;
      $display("FAIL single_rsp: gnt=%b valid=%b id=%0d sum=%0d, want 0000/1/2/14",
               gnt, rsp_valid, rsp_id, rsp_sum);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_exhaustive();
    rsp_ready = 1'b1;
    for (int x = 0; x < 64; x++) begin
      for (int y = 0; y < 64; y++) begin
        req = 4'b0001; x_in[5:0] = 6'(x); y_in[5:0] = 6'(y);
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
          errors++;
          $display("FAIL exh_gnt x=%0d y=%0d: gnt=%b, want 0001", x, y, gnt);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 7'(x + y)) begin
          errors++;
          $display("FAIL exh_sum x=%0d y=%0d: valid=%b id=%0d sum=%0d, want 1/0/%0d",
                   x, y, rsp_valid, rsp_id, rsp_sum, x + y);
        end
        tick();
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_k;
    rst = 1'b1; req = 4'b0000; tick(); tick(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      x_in[k*6 +: 6] = 6'(k + 10);
      y_in[k*6 +: 6] = 6'(k);
    end
    rsp_ready = 1'b1;
    req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      exp_k = n % 4;
      tick();
      checks++;
      if (gnt !== 4'(1 << exp_k)) begin
        errors++;
        $display("FAIL rr_gnt n=%0d: gnt=%b, want %b", n, gnt, 4'(1 << exp_k));
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_k) || rsp_sum !== 7'(2 * exp_k + 10) ||
          gnt !== 4'b0000) begin
        errors++;
        $display("FAIL rr_rsp n=%0d: valid=%b id=%0d sum=%0d gnt=%b, want 1/%0d/%0d/0000",
                 n, rsp_valid, rsp_id, rsp_sum, gnt, exp_k, 2 * exp_k + 10);
      end
      tick();
    end
    req = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    // ptr is 2 after the last round-robin grant (requester 1).
    x_in[18 +: 6] = 6'd40; y_in[18 +: 6] = 6'd30;
    req = 4'b1000; rsp_ready = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL bp_gnt: gnt=%b, want 1000", gnt);
    end
    req = 4'b1111;
    x_in[0 +: 6] = 6'd1; y_in[0 +: 6] = 6'd2;
    x_in[18 +: 6] = 6'd0;
    tick();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 7'd70 || gnt !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold c=%0d: valid=%b id=%0d sum=%0d gnt=%b, want 1/3/70/0000",
                 c, rsp_valid, rsp_id, rsp_sum, gnt);
      end
      if (c < 5) tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL bp_release: valid=%b gnt=%b, want 0/0000", rsp_valid, gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL bp_next_gnt: gnt=%b, want 0001", gnt);
    end
    // Operand change after grant must not disturb the in-flight sum.
    req = 4'b0000; x_in[0 +: 6] = 6'd63;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 7'd3) begin
      errors++;
      $display("FAIL late_operand: valid=%b id=%0d sum=%0d, want 1/0/3", rsp_valid, rsp_id, rsp_sum);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    x_in[6 +: 6] = 6'd7; y_in[6 +: 6] = 6'd8;
    req = 4'b0010; rsp_ready = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mr_gnt: gnt=%b, want 0010", gnt);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 7'd15) begin
      errors++;
      $display("FAIL mr_rsp: valid=%b sum=%0d, want 1/15", rsp_valid, rsp_sum);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 7'd0 || rsp_id !== 2'd0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL mr_clear: valid=%b sum=%0d id=%0d gnt=%b, want 0/0/0/0000",
               rsp_valid, rsp_sum, rsp_id, gnt);
    end
    rst = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin
        errors++;
        $display("FAIL mr_stale c=%0d: valid=%b gnt=%b, want 0/0000", c, rsp_valid, gnt);
      end
    end
  endtask

`ifdef ADDER_ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
    rsp_ready = 1'b1; req = 4'b0010;
    for (int c = 0; c < 900; c++) tick();
    req = 4'b0000;
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (stat_cnt[k*8 +: 8] !== ((k == 1) ? 8'd255 : 8'd0)) begin
        errors++;
        $display("FAIL stat_cnt[%0d]: got %0d, want %0d", k, stat_cnt[k*8 +: 8],
                 (k == 1) ? 255 : 0);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_exhaustive();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
`ifdef ADDER_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
